// File: rtl/irig_pkg.sv
// irig_pkg: shared constants, field limit table and FSM state type
// for the IRIG frame accumulator.
package irig_pkg;

    localparam int FLD_SEC  = 0;
    localparam int FLD_MIN  = 1;
    localparam int FLD_HOUR = 2;
    localparam int FLD_DAY  = 3;
    localparam int FLD_YEAR = 4;

    // Internal accumulator width (holds up to 3 BCD digits).
    localparam int ACC_W = 10;

    localparam int ERR_BCD   = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_MALF  = 2;
    localparam int ERR_OVR   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Fields beyond the year have no limits apart from the width check.
    function automatic logic [ACC_W-1:0] fld_lo(input int idx);
        case (idx)
            FLD_DAY: fld_lo = ACC_W'(1);
            default: fld_lo = '0;
        endcase
    endfunction

    function automatic logic [ACC_W-1:0] fld_hi(input int idx);
        case (idx)
            FLD_SEC:  fld_hi = ACC_W'(59);
            FLD_MIN:  fld_hi = ACC_W'(59);
            FLD_HOUR: fld_hi = ACC_W'(23);
            FLD_DAY:  fld_hi = ACC_W'(366);
            FLD_YEAR: fld_hi = ACC_W'(99);
            default:  fld_hi = '1;
        endcase
    endfunction

endpackage

// File: rtl/irig_frame_accumulator_if.sv
// irig_frame_accumulator_if: committed-timestamp drain handshake.
// master: ts_fields/ts_valid out, ts_ready in. slave: the consumer.
interface irig_frame_accumulator_if #(
    parameter int NUM_FIELDS = 5,
    parameter int FIELD_W    = 9
) ();
    logic [NUM_FIELDS*FIELD_W-1:0] ts_fields;
    logic                          ts_valid;
    logic                          ts_ready;

    modport master (
        output ts_fields,
        output ts_valid,
        input  ts_ready
    );

    modport slave (
        input  ts_fields,
        input  ts_valid,
        output ts_ready
    );
endinterface

// File: rtl/irig_bcd_weight.sv
// irig_bcd_weight: maps (bit index, digit index) to its decimal weight
// and flags whether the digit index is legal for MAX_DIGITS.
// Ports: i_bit_idx, i_digit_idx in; o_weight, o_digit_ok out.
module irig_bcd_weight
    import irig_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic [1:0]       i_bit_idx,
    input  logic [1:0]       i_digit_idx,
    output logic [ACC_W-1:0] o_weight,
    output logic             o_digit_ok
);

    logic [ACC_W-1:0] w_base;

    always_comb begin
        w_base     = ACC_W'(1) << i_bit_idx;
        o_digit_ok = int'(i_digit_idx) < MAX_DIGITS;
        case (i_digit_idx)
            2'd0:    o_weight = w_base;
            2'd1:    o_weight = w_base * ACC_W'(10);
            2'd2:    o_weight = w_base * ACC_W'(100);
            default: o_weight = '0;
        endcase
    end

endmodule

// File: rtl/irig_frame_accumulator.sv
// irig_frame_accumulator: accumulates weighted BCD bits into timestamp
// fields over one IRIG frame, checks them and commits atomically.
// Ports: clk, rst_n; frame_start/frame_end pulses; bit_valid, bcd_bit,
// bcd_bit_idx, bcd_digit_idx, field_sel bit bus; ts_if drain handshake
// (ts_fields, ts_valid, ts_ready); frame_err pulse and err_code.
module irig_frame_accumulator
    import irig_pkg::*;
#(
    parameter int NUM_FIELDS = 5,
    parameter int MAX_DIGITS = 3,
    parameter int FIELD_W    = 9,
    parameter int CHECK_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  bit_valid,
    input  logic                  bcd_bit,
    input  logic [1:0]            bcd_bit_idx,
    input  logic [1:0]            bcd_digit_idx,
    input  logic [NUM_FIELDS-1:0] field_sel,
    irig_frame_accumulator_if.master ts_if,
    output logic                  frame_err,
    output logic [3:0]            err_code
);

    typedef logic [NUM_FIELDS-1:0][ACC_W-1:0]         acc_t;
    typedef logic [NUM_FIELDS-1:0][MAX_DIGITS-1:0][3:0] nib_t;

    state_t                        r_state;
    acc_t                          r_acc;
    nib_t                          r_nib;
    logic                          r_malf;
    acc_t                          r_snap_acc;
    nib_t                          r_snap_nib;
    logic                          r_snap_malf;
    logic                          r_restart;
    logic [NUM_FIELDS*FIELD_W-1:0] r_ts_fields;
    logic                          r_ts_valid;
    logic                          r_frame_err;
    logic [3:0]                    r_err_code;

    logic [ACC_W-1:0]              w_weight;
    logic                          w_digit_ok;
    logic                          w_sel_ok;
    logic                          w_in_frame;
    logic                          w_hit;
    logic                          w_malf_bit;
    acc_t                          w_acc_nxt;
    nib_t                          w_nib_nxt;
    logic [NUM_FIELDS-1:0]         w_fld_bcd;
    logic [NUM_FIELDS-1:0]         w_fld_rng;
    logic [3:0]                    w_err;
    logic [NUM_FIELDS*FIELD_W-1:0] w_fields;

    irig_bcd_weight #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_weight (
        .i_bit_idx   (bcd_bit_idx),
        .i_digit_idx (bcd_digit_idx),
        .o_weight    (w_weight),
        .o_digit_ok  (w_digit_ok)
    );

    // A bit coinciding with frame_start belongs to no frame.
    assign w_in_frame = (r_state == ACCUM) && bit_valid && !frame_start;
    assign w_sel_ok   = $onehot(field_sel);
    assign w_hit      = w_in_frame && w_sel_ok && w_digit_ok;
    assign w_malf_bit = w_in_frame && !(w_sel_ok && w_digit_ok);

    always_comb begin
        w_acc_nxt = r_acc;
        w_nib_nxt = r_nib;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (w_hit && field_sel[f]) begin
                if (bcd_bit)
                    w_acc_nxt[f] = r_acc[f] + w_weight;
                for (int d = 0; d < MAX_DIGITS; d++)
                    if (int'(bcd_digit_idx) == d)
                        w_nib_nxt[f][d][bcd_bit_idx] = bcd_bit;
            end
        end
    end

    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_chk
        logic [MAX_DIGITS-1:0] w_bad;
        logic                  w_wide;
        logic                  w_lim;

        for (genvar d = 0; d < MAX_DIGITS; d++) begin : g_dig
            assign w_bad[d] = r_snap_nib[f][d][3]
                            & (r_snap_nib[f][d][2] | r_snap_nib[f][d][1]);
        end

        assign w_wide = int'(r_snap_acc[f]) >= (1 << FIELD_W);

        if (CHECK_EN != 0) begin : g_lim
            assign w_lim = (r_snap_acc[f] < fld_lo(f))
                         || (r_snap_acc[f] > fld_hi(f));
        end else begin : g_nolim
            assign w_lim = 1'b0;
        end

        assign w_fld_bcd[f] = |w_bad;
        assign w_fld_rng[f] = w_wide | w_lim;
    end

    always_comb begin
        w_err            = '0;
        w_err[ERR_BCD]   = |w_fld_bcd;
        w_err[ERR_RANGE] = |w_fld_rng;
        w_err[ERR_MALF]  = r_snap_malf;
    end

    always_comb begin
        w_fields = '0;
        for (int f = 0; f < NUM_FIELDS; f++)
            w_fields[f*FIELD_W +: FIELD_W] = FIELD_W'(r_snap_acc[f]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_nib       <= '0;
            r_malf      <= 1'b0;
            r_snap_acc  <= '0;
            r_snap_nib  <= '0;
            r_snap_malf <= 1'b0;
            r_restart   <= 1'b0;
            r_ts_fields <= '0;
            r_ts_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_frame_err <= 1'b0;

            if (r_ts_valid && ts_if.ts_ready)
                r_ts_valid <= 1'b0;

            if (frame_start) begin
                r_acc  <= '0;
                r_nib  <= '0;
                r_malf <= 1'b0;
            end else if (r_state == ACCUM) begin
                r_acc  <= w_acc_nxt;
                r_nib  <= w_nib_nxt;
                r_malf <= r_malf | w_malf_bit;
            end

            case (r_state)
                IDLE: begin
                    if (frame_start)
                        r_state <= ACCUM;
                end
                ACCUM: begin
                    if (frame_end) begin
                        r_snap_acc  <= w_acc_nxt;
                        r_snap_nib  <= w_nib_nxt;
                        r_snap_malf <= r_malf | w_malf_bit;
                        r_restart   <= frame_start;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    r_restart <= 1'b0;
                    r_state   <= (r_restart || frame_start) ? ACCUM : IDLE;
                    if (|w_err) begin
                        r_frame_err <= 1'b1;
                        r_err_code  <= w_err;
                    end else begin
                        // Unconsumed frame gets overwritten: flag overrun.
                        r_ts_fields <= w_fields;
                        r_ts_valid  <= 1'b1;
                        r_err_code  <= '0;
                        r_err_code[ERR_OVR] <= r_ts_valid && !ts_if.ts_ready;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ts_if.ts_fields = r_ts_fields;
    assign ts_if.ts_valid  = r_ts_valid;
    assign frame_err       = r_frame_err;
    assign err_code        = r_err_code;

endmodule

// File: tb/tb_irig_frame_accumulator.sv
// tb_irig_frame_accumulator: drives two instances (range check on/off)
// with directed and random frames against a decimal-level model.
module tb_irig_frame_accumulator;
    import irig_pkg::*;

    localparam int NF = 5;
    localparam int MD = 3;
    localparam int FW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bcd_bit = 1'b0;
    logic [1:0]    bcd_bit_idx = '0;
    logic [1:0]    bcd_digit_idx = '0;
    logic [NF-1:0] field_sel = '0;
    logic          ts_ready = 1'b0;
    logic          ferr0, ferr1;
    logic [3:0]    ecode0, ecode1;

    always #5 clk = ~clk;

    irig_frame_accumulator_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) if0 ();
    irig_frame_accumulator_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) if1 ();

    assign if0.ts_ready = ts_ready;
    assign if1.ts_ready = ts_ready;

    irig_frame_accumulator #(
        .NUM_FIELDS(NF), .MAX_DIGITS(MD), .FIELD_W(FW), .CHECK_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .frame_end(frame_end),
        .bit_valid(bit_valid), .bcd_bit(bcd_bit),
        .bcd_bit_idx(bcd_bit_idx), .bcd_digit_idx(bcd_digit_idx),
        .field_sel(field_sel), .ts_if(if0.master),
        .frame_err(ferr0), .err_code(ecode0)
    );

    irig_frame_accumulator #(
        .NUM_FIELDS(NF), .MAX_DIGITS(MD), .FIELD_W(FW), .CHECK_EN(0)
    ) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .frame_end(frame_end),
        .bit_valid(bit_valid), .bcd_bit(bcd_bit),
        .bcd_bit_idx(bcd_bit_idx), .bcd_digit_idx(bcd_digit_idx),
        .field_sel(field_sel), .ts_if(if1.master),
        .frame_err(ferr1), .err_code(ecode1)
    );

    int LO[NF] = '{0, 0, 0, 1, 0};
    int HI[NF] = '{59, 59, 23, 366, 99};

    // Model of the frame in progress: decimal value and raw nibble per digit.
    int m_val[NF];
    int m_nib[NF][MD];
    bit m_malf;

    // Expected outputs per instance (0: range check on, 1: off).
    int       e_fields[2][NF];
    bit       e_valid[2];
    bit       e_ferr[2];
    bit [3:0] e_err[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic gv(int k);
        return (k == 0) ? if0.ts_valid : if1.ts_valid;
    endfunction

    function automatic logic gferr(int k);
        return (k == 0) ? ferr0 : ferr1;
    endfunction

    function automatic logic [3:0] gerr(int k);
        return (k == 0) ? ecode0 : ecode1;
    endfunction

    function automatic logic [FW-1:0] gfld(int k, int f);
        logic [NF*FW-1:0] v;
        v = (k == 0) ? if0.ts_fields : if1.ts_fields;
        return v[f*FW +: FW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        m_malf = 1'b0;
        for (int f = 0; f < NF; f++) begin
            m_val[f] = 0;
            for (int d = 0; d < MD; d++) m_nib[f][d] = 0;
        end
    endtask

    task automatic m_reset();
        m_clear();
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 1'b0;
            e_ferr[k]  = 1'b0;
            e_err[k]   = '0;
            for (int f = 0; f < NF; f++) e_fields[k][f] = 0;
        end
    endtask

    task automatic m_commit(input int k);
        bit [3:0] e;
        int       v;
        e = '0;
        for (int f = 0; f < NF; f++) begin
            for (int d = 0; d < MD; d++)
                if (m_nib[f][d] > 9) e[0] = 1'b1;
            v = m_val[f] % 1024;
            if (v >= 512) e[1] = 1'b1;
            if (k == 0 && (v < LO[f] || v > HI[f])) e[1] = 1'b1;
        end
        e[2] = m_malf;
        if (e != 0) begin
            e_ferr[k] = 1'b1;
            e_err[k]  = e;
        end else begin
            e_ferr[k] = 1'b0;
            e_err[k]  = e_valid[k] ? 4'b1000 : 4'b0000;
            e_valid[k] = 1'b1;
            for (int f = 0; f < NF; f++) e_fields[k][f] = m_val[f];
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), 64'(gv(k)), 64'(e_valid[k]));
            chk($sformatf("%s_ferr%0d", tag, k), 64'(gferr(k)), 64'(e_ferr[k]));
            chk($sformatf("%s_err%0d", tag, k), 64'(gerr(k)), 64'(e_err[k]));
            for (int f = 0; f < NF; f++)
                chk($sformatf("%s_fld%0d_%0d", tag, k, f),
                    64'(gfld(k, f)), 64'(e_fields[k][f]));
        end
    endtask

    task automatic drive_bit(input logic [NF-1:0] sel, input int d,
                             input int b, input bit v);
        field_sel     = sel;
        bcd_digit_idx = 2'(d);
        bcd_bit_idx   = 2'(b);
        bcd_bit       = v;
        bit_valid     = 1'b1;
        tick();
        bit_valid     = 1'b0;
        bcd_bit       = 1'b0;
    endtask

    // Sends all four bits of a digit; a nibble above 9 is deliberately bad.
    task automatic send_digit(input int f, input int d, input int nib);
        for (int b = 0; b < 4; b++)
            drive_bit(NF'(1) << f, d, b, bit'((nib >> b) & 1));
        m_val[f]    += nib * (10 ** d);
        m_nib[f][d]  = nib;
    endtask

    task automatic send_field(input int f, input int v);
        for (int d = 0; d < MD; d++)
            send_digit(f, d, (v / (10 ** d)) % 10);
    endtask

    task automatic send_frame(input int s, input int mi, input int h,
                              input int dy, input int y);
        send_field(FLD_SEC, s);
        send_field(FLD_MIN, mi);
        send_field(FLD_HOUR, h);
        send_field(FLD_DAY, dy);
        send_field(FLD_YEAR, y);
    endtask

    task automatic send_malformed();
        case ($urandom_range(0, 2))
            0:       drive_bit('0, 0, 0, 1'b1);
            1:       drive_bit(NF'(5'b00011), 0, 0, 1'b1);
            default: drive_bit(NF'(1), 3, 0, 1'b1);
        endcase
        m_malf = 1'b1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_clear();
    endtask

    task automatic end_frame(input bit with_start, input string tag);
        frame_end   = 1'b1;
        frame_start = with_start;
        tick();
        frame_end   = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_hold_valid%0d", tag, k), 64'(gv(k)), 64'(e_valid[k]));
            chk($sformatf("%s_hold_ferr%0d", tag, k), 64'(gferr(k)), 64'(0));
        end
        tick();
        m_commit(0);
        m_commit(1);
        if (with_start) m_clear();
        check_outputs(tag);
        tick();
        for (int k = 0; k < 2; k++) begin
            e_ferr[k] = 1'b0;
            chk($sformatf("%s_ferr_end%0d", tag, k), 64'(gferr(k)), 64'(0));
        end
    endtask

    task automatic drain(input string tag);
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 1'b0;
            chk($sformatf("%s_valid%0d", tag, k), 64'(gv(k)), 64'(0));
        end
    endtask

    initial begin
        int v;
        m_reset();
        tick();
        tick();
        check_outputs("reset");
        rst_n = 1'b1;
        tick();

        start_frame();
        send_field(FLD_SEC, 37);
        send_frame(0, 59, 23, 366, 24);
        end_frame(1'b0, "good");

        start_frame();
        send_frame(1, 2, 3, 4, 5);
        end_frame(1'b0, "overrun");
        drain("drain1");

        start_frame();
        send_digit(FLD_SEC, 0, 10);
        send_frame(0, 0, 0, 1, 0);
        end_frame(1'b0, "nib10");

        start_frame();
        send_frame(0, 0, 24, 1, 0);
        end_frame(1'b0, "hour24");
        drain("drain2");

        start_frame();
        send_frame(0, 0, 0, 0, 0);
        end_frame(1'b0, "day0");
        drain("drain3");

        start_frame();
        send_frame(10, 20, 5, 100, 50);
        send_malformed();
        end_frame(1'b0, "malf");

        start_frame();
        send_frame(44, 33, 22, 111, 11);
        end_frame(1'b1, "startend");
        send_frame(5, 0, 0, 1, 0);
        end_frame(1'b0, "after_se");

        start_frame();
        send_field(FLD_SEC, 12);
        rst_n = 1'b0;
        #2;
        m_reset();
        check_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        start_frame();
        send_frame(3, 0, 0, 1, 0);
        end_frame(1'b0, "post_rst");

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0)
                drive_bit(NF'(1), 0, 0, 1'b1);
            start_frame();
            for (int f = 0; f < NF; f++) begin
                if ($urandom_range(0, 4) == 0)
                    v = int'($urandom_range(0, 999));
                else
                    v = int'($urandom_range(LO[f], HI[f]));
                send_field(f, v);
            end
            if ($urandom_range(0, 7) == 0)
                send_digit(int'($urandom_range(0, NF-1)),
                           int'($urandom_range(0, MD-1)),
                           int'($urandom_range(10, 15)));
            if ($urandom_range(0, 7) == 0)
                send_malformed();
            end_frame(1'b0, $sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) == 1)
                drain($sformatf("rnd_drain%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
